calc_cmd_issuer: RTL and testbench
==================================

Name: calc_cmd_issuer

Overview:
Upstream command stage for the calculator block. Buffers operation requests (a, b, op_code) arriving on a valid/ready interface in a small FIFO and drives one command at a time onto the calculator's a/b/op_code inputs. It waits out the calculator's registered latency, captures the result, and returns it on a valid/ready response interface. It also flags divide-by-zero before the result reaches software-facing logic.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
CALC_LATENCY, 1, clock edges from calc_* inputs changing to calc_result valid (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full
cmd_a  input  16  operand a
cmd_b  input  16  operand b
cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div
calc_a  output  16  to calculator a (registered)
calc_b  output  16  to calculator b (registered)
calc_op_code  output  2  to calculator op_code (registered)
calc_result  input  16  from calculator result
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  16  captured result
rsp_op  output  2  op of this response
rsp_div0  output  1  op was 11 with b==0
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): FIFO emptied, state IDLE, latency counter 0, all outputs 0 except cmd_ready=1. In-flight command and pending response are dropped.
- Push when cmd_valid && cmd_ready at a clock edge. There is no push when full, even if a pop happens the same cycle.
- Pop decisions use the registered FIFO count, so a command pushed at edge E can be popped at E+1 at the earliest.
- FSM:
  - IDLE: if FIFO non-empty, pop and load calc_a/calc_b/calc_op_code from the head. Latch op and div0 = (op==11 && b==0). Set cnt=0 and go to ISSUE.
  - ISSUE: cnt increments each edge. When cnt==CALC_LATENCY, capture at the next edge and go to RESP. The capture value is calc_result, or 16'hFFFF if div0.
  - RESP: rsp_valid=1. rsp_result, rsp_op and rsp_div0 stay stable until rsp_valid && rsp_ready.
    - On handshake with FIFO non-empty: pop the next command into calc_* in the same edge and go to ISSUE.
    - On handshake with FIFO empty: go to IDLE and drop rsp_valid.
- calc_* hold their last command after completion (no return to 0). The calculator's inputs only change on a pop.
- Latency: command handshake at edge E with the block idle gives rsp_valid high after edge E+CALC_LATENCY+2.
- Throughput: with rsp_ready held high, one response every CALC_LATENCY+2 cycles.
- Arithmetic: results pass through unmodified at 16 bits. Wrap and truncation are the calculator's, e.g. sub underflow or mul overflow mod 2^16.
- Order: responses leave strictly in command order. No reordering or dropping except at reset.
- Reset mid-operation (any state): immediate return to reset values. No response for in-flight or queued commands.

Test Plan:
- Single add, CALC_LATENCY=1: a=10, b=5, op=00 accepted at edge E -> rsp_valid rises after E+3, rsp_result=15, rsp_op=00, rsp_div0=0, calc_a=10 held afterwards.
- Back-to-back stream, rsp_ready=1: (10,5) with ops 00,01,10,11 pushed consecutively -> responses 15, 5, 50, 2 in order, spaced 3 cycles apart; busy low after the last handshake.
- Divide by zero and overflow: (7,0,op 11) -> rsp_result=16'hFFFF, rsp_div0=1. (300,300,op 10) -> rsp_result=24464, rsp_div0=0. (3,5,op 01) -> 65534.
- Full FIFO and backpressure: rsp_ready=0, push 6 commands on consecutive cycles -> 5 accepted (1 in flight + 4 queued), cmd_ready=0 from the 6th cycle. rsp_valid and data stay stable across 10 stalled cycles. Releasing rsp_ready drains all 5 in order, and cmd_ready rises the cycle after the first pop.
- Reset mid-operation: assert rst_n=0 asynchronously while in ISSUE with 2 queued -> outputs go 0 without waiting for a clock, cmd_ready=1. After release with no new commands, rsp_valid stays 0 for 20 cycles.
- CALC_LATENCY=3 build: single div a=100, b=7 -> rsp_valid after E+5, rsp_result=14.

Source files
------------

// File: rtl/calc_cmd_issuer.sv
// Command issuer for the calculator: buffers (a, b, op) requests in a FIFO, drives one at a time
// into the calculator, waits out its latency and returns the captured result on a valid/ready port.
`timescale 1ns/1ps
module calc_cmd_issuer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CALC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [1:0]  cmd_op,
    output logic [15:0] calc_a,
    output logic [15:0] calc_b,
    output logic [1:0]  calc_op_code,
    input  logic [15:0] calc_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_op,
    output logic        rsp_div0,
    output logic        busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(CALC_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state;
    logic [15:0]      mem_a  [FIFO_DEPTH];
    logic [15:0]      mem_b  [FIFO_DEPTH];
    logic [1:0]       mem_op [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LAT_W-1:0] cnt;
    logic             div0_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // Pop only from the registered count, so a fresh push is visible one edge later.
    assign pop       = !empty && ((state == IDLE) || (state == RESP && rsp_ready));
    assign busy      = (state != IDLE) || !empty;

    // Storage carries no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cnt          <= '0;
            div0_q       <= 1'b0;
            calc_a       <= '0;
            calc_b       <= '0;
            calc_op_code <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_op       <= '0;
            rsp_div0     <= 1'b0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                calc_a       <= mem_a[rd_ptr];
                calc_b       <= mem_b[rd_ptr];
                calc_op_code <= mem_op[rd_ptr];
                div0_q       <= (mem_op[rd_ptr] == 2'b11) && (mem_b[rd_ptr] == 16'd0);
                cnt          <= '0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == LAT_W'(CALC_LATENCY)) begin
                        rsp_result <= div0_q ? 16'hFFFF : calc_result;
                        rsp_op     <= calc_op_code;
                        rsp_div0   <= div0_q;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Bench for calc_cmd_issuer: directed and random stimulus against a queue-based response model,
// plus a behavioural calculator model feeding calc_result at latency 1 and latency 3.
`timescale 1ns/1ps
module tb_calc_cmd_issuer;
    typedef struct {
        logic [15:0] result;
        logic [1:0]  op;
        logic        div0;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_div0, busy;
    logic [15:0] cmd_a, cmd_b, calc_a, calc_b, calc_result, rsp_result;
    logic [1:0]  cmd_op, calc_op_code, rsp_op;

    logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_div03, busy3;
    logic [15:0] cmd_a3, cmd_b3, calc_a3, calc_b3, calc_result3, rsp_result3;
    logic [1:0]  cmd_op3, calc_op_code3, rsp_op3;
    logic [15:0] pipe3 [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    rsp_t model_q[$];
    int   hs_cyc[$];

    calc_cmd_issuer #(.FIFO_DEPTH(4), .CALC_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .calc_a(calc_a), .calc_b(calc_b),
        .calc_op_code(calc_op_code), .calc_result(calc_result), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_div0(rsp_div0),
        .busy(busy));

    calc_cmd_issuer #(.FIFO_DEPTH(4), .CALC_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3), .calc_a(calc_a3), .calc_b(calc_b3),
        .calc_op_code(calc_op_code3), .calc_result(calc_result3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .rsp_op(rsp_op3), .rsp_div0(rsp_div03),
        .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculator stand-in: divide by zero yields 0 here, so the issuer's FFFF override is visible.
    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        logic [31:0] p;
        p = a * b;
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return p[15:0];
            default: return (b == 16'd0) ? 16'd0 : a / b;
        endcase
    endfunction

    always @(posedge clk) begin
        calc_result <= alu(calc_a, calc_b, calc_op_code);
        pipe3[0]    <= alu(calc_a3, calc_b3, calc_op_code3);
        pipe3[1]    <= pipe3[0];
        pipe3[2]    <= pipe3[1];
    end
    assign calc_result3 = pipe3[2];

    function automatic rsp_t expect_of(input int unsigned a, input int unsigned b, input int unsigned op);
        rsp_t r;
        int unsigned v;
        case (op)
            0:       v = (a + b) % 65536;
            1:       v = (a + 65536 - b) % 65536;
            2:       v = (a * b) % 65536;
            default: v = (b == 0) ? 65535 : a / b;
        endcase
        r.result = v[15:0];
        r.op     = op[1:0];
        r.div0   = (op == 3) && (b == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the negedge, book the handshakes the next posedge will perform.
    task automatic drive(input logic cv, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic rr);
        rsp_t e;
        cmd_valid = cv; cmd_a = a; cmd_b = b; cmd_op = op; rsp_ready = rr;
        #1;
        if (cv && cmd_ready) model_q.push_back(expect_of(a, b, op));
        if (rsp_valid && rr) begin
            if (model_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = model_q.pop_front();
                chk("rsp_result", 32'(rsp_result), 32'(e.result));
                chk("rsp_op", 32'(rsp_op), 32'(e.op));
                chk("rsp_div0", 32'(rsp_div0), 32'(e.div0));
            end
            hs_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 16'd0, 16'd0, 2'd0, rr);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (model_q.size() == 0 && !rsp_valid) break;
            idle(1'b1);
        end
        chk("drain_left", 32'(model_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int          first;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; rsp_ready = 0;
        cmd_valid3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_op3 = 0; rsp_ready3 = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_calc_a", 32'(calc_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add: push at E, response visible after E+3, calc_a held afterwards.
        drive(1'b1, 16'd10, 16'd5, 2'b00, 1'b0);
        chk("lat_e0", 32'(rsp_valid), 32'd0);
        idle(1'b0);
        chk("lat_e1", 32'(rsp_valid), 32'd0);
        idle(1'b0);
        chk("lat_e2", 32'(rsp_valid), 32'd0);
        chk("calc_a_load", 32'(calc_a), 32'd10);
        idle(1'b0);
        chk("lat_e3", 32'(rsp_valid), 32'd1);
        idle(1'b1);
        chk("after_hs_valid", 32'(rsp_valid), 32'd0);
        chk("calc_a_held", 32'(calc_a), 32'd10);
        chk("after_hs_busy", 32'(busy), 32'd0);

        // Back-to-back stream of four ops with rsp_ready high: one response every 3 cycles.
        hs_cyc.delete();
        for (int k = 0; k < 4; k++) drive(1'b1, 16'd10, 16'd5, 2'(k), 1'b1);
        drain(60);
        chk("stream_count", 32'(hs_cyc.size()), 32'd4);
        for (int k = 1; k < hs_cyc.size(); k++)
            chk("stream_spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd3);

        // Divide by zero, multiply overflow, subtract underflow.
        drive(1'b1, 16'd7, 16'd0, 2'b11, 1'b1);
        drain(20);
        drive(1'b1, 16'd300, 16'd300, 2'b10, 1'b1);
        drain(20);
        drive(1'b1, 16'd3, 16'd5, 2'b01, 1'b1);
        drain(20);

        // Full FIFO under backpressure: sixth push is refused.
        for (int k = 0; k < 6; k++) begin
            chk("full_cmd_ready", 32'(cmd_ready), (k < 5) ? 32'd1 : 32'd0);
            drive(1'b1, 16'(100 + k), 16'(k + 1), 2'b00, 1'b0);
        end
        chk("full_queued", 32'(model_q.size()), 32'd5);
        chk("stall_valid0", 32'(rsp_valid), 32'd1);
        held = rsp_result;
        for (int k = 0; k < 10; k++) begin
            idle(1'b0);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_result), 32'(held));
        end
        chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        idle(1'b1);
        chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
        drain(60);

        // Latency-3 build: 100/7 visible after E+5.
        cmd_valid3 = 1; cmd_a3 = 16'd100; cmd_b3 = 16'd7; cmd_op3 = 2'b11;
        @(negedge clk);
        cmd_valid3 = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid3 && first < 0) first = i;
            @(negedge clk);
        end
        chk("lat3_cycles", 32'(first), 32'd5);
        chk("lat3_result", 32'(rsp_result3), 32'd14);
        chk("lat3_div0", 32'(rsp_div03), 32'd0);
        rsp_ready3 = 1;
        @(negedge clk);
        rsp_ready3 = 0;
        chk("lat3_done", 32'(rsp_valid3), 32'd0);

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 1) == 1), 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 300)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
        end
        drain(100);

        // Reset in ISSUE with two queued commands.
        drive(1'b1, 16'd1, 16'd2, 2'b00, 1'b0);
        drive(1'b1, 16'd3, 16'd4, 2'b00, 1'b0);
        drive(1'b1, 16'd5, 16'd6, 2'b00, 1'b0);
        cmd_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_calc_a", 32'(calc_a), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1'b1);
            if (rsp_valid) first++;
        end
        chk("post_rst_quiet", 32'(first), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
